// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared types, colour-order encodings and elaboration-time
//                helpers for the WS2812 chain driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Frame-level controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    // Wire colour orders
    localparam int c_ORDER_GRB = 0;
    localparam int c_ORDER_RGB = 1;

    // Nanoseconds to clock cycles, rounded to nearest
    function automatic int cyc(input longint clk_hz, input longint ns);
        return int'((clk_hz / 64'd1000000 * ns + 64'd500) / 64'd1000);
    endfunction

    // Address width for a pixel store of n entries (at least one bit)
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reorder a {R,G,B} store word into the order the chain expects on the wire
    function automatic logic [23:0] to_wire(input logic [23:0] rgb, input int order);
        if (order == c_ORDER_RGB) begin
            return rgb;
        end
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_bit_timer
//  Description : Generates one NRZ bit cell: high for T0H/T1H cycles, low for
//                the remainder of BIT cycles. A go strobe in the last cycle of
//                a cell starts the next cell with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_timer #(
    parameter int T0H_CYC = 4,
    parameter int T1H_CYC = 8,
    parameter int BIT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_go,
    input  logic i_bit,
    output logic o_ws,
    output logic o_bit_end
);

    localparam int               c_CW   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BIT_CYC - 1);
    localparam logic [c_CW-1:0] c_T0H  = c_CW'(T0H_CYC);
    localparam logic [c_CW-1:0] c_T1H  = c_CW'(T1H_CYC);

    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_hi;
    logic            r_active;
    logic            r_ws;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_bit_end;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_bit_end = r_active && (r_cnt == c_LAST);
    assign o_bit_end = w_bit_end;
    assign o_ws      = r_ws;

    // Cell counter and registered line output; go has priority so cells chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_active <= 1'b0;
            r_ws     <= 1'b0;
        end else if (i_go) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_hi     <= i_bit ? c_T1H : c_T0H;
            r_ws     <= 1'b1;
        end else if (w_bit_end) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_ws     <= 1'b0;
        end else if (r_active) begin
            r_cnt <= w_cnt_nxt;
            r_ws  <= (w_cnt_nxt < r_hi);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_chain_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_chain_driver
//  Description : Streams NUM_LEDS pixels from a synchronous pixel store onto a
//                WS2812 one-wire chain, prefetching the next pixel so pixels
//                follow each other without gaps, then holds the latch gap and
//                pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int NUM_LEDS    = 20,
    parameter int T0H_NS      = 350,
    parameter int T1H_NS      = 700,
    parameter int BIT_NS      = 1250,
    parameter int RESET_US    = 80,
    parameter int COLOR_ORDER = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [addr_w(NUM_LEDS)-1:0]   pix_addr,
    input  logic [23:0]                   pix_data,
    output logic                          busy,
    output logic                          done,
    output logic                          ws_data
);

    localparam int c_T0H = cyc(CLK_HZ, T0H_NS);
    localparam int c_T1H = cyc(CLK_HZ, T1H_NS);
    localparam int c_BIT = cyc(CLK_HZ, BIT_NS);
    localparam int c_RST = cyc(CLK_HZ, longint'(RESET_US) * 1000);
    localparam int c_AW  = addr_w(NUM_LEDS);
    localparam int c_LW  = (c_RST > 1) ? $clog2(c_RST) : 1;

    localparam logic [c_AW-1:0] c_ONE      = c_AW'(1);
    localparam logic [c_AW-1:0] c_LAST_PIX = c_AW'(NUM_LEDS - 1);
    localparam logic [c_LW-1:0] c_RST_LAST = c_LW'(c_RST - 1);
    localparam logic [4:0]      c_LAST_BIT = 5'd23;

    // Refuse to elaborate with a waveform that cannot be produced
    if (c_T1H >= c_BIT || c_T0H < 1 || c_RST < 1 || NUM_LEDS < 1 || NUM_LEDS > 1024) begin : g_bad_params
        $error("ws2812_chain_driver: invalid timing or NUM_LEDS");
    end

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [c_AW-1:0]   r_pix_addr;
    logic [c_AW-1:0]   r_pix_idx;
    logic [4:0]        r_bit_idx;
    logic [23:0]       r_shift;
    logic [23:0]       r_hold;
    logic [c_LW-1:0]   r_latch_cnt;

    logic [23:0]       w_fetch_word;
    logic [c_AW-1:0]   w_next_idx;
    logic              w_last_bit;
    logic              w_go;
    logic              w_bit;
    logic              w_bit_end;

    assign w_fetch_word = to_wire(pix_data, COLOR_ORDER);
    assign w_next_idx   = r_pix_idx + c_ONE;
    assign w_last_bit   = (r_bit_idx == c_LAST_BIT) && (r_pix_idx == c_LAST_PIX);

    assign pix_addr = r_pix_addr;
    assign busy     = r_busy;
    assign done     = r_done;

    // Next bit to start: first bit of frame, next shift bit, or first bit of held pixel
    always_comb begin
        w_go  = 1'b0;
        w_bit = 1'b0;
        if (r_state == S_FETCH) begin
            w_go  = 1'b1;
            w_bit = w_fetch_word[23];
        end else if (r_state == S_SEND && w_bit_end && !w_last_bit) begin
            w_go  = 1'b1;
            w_bit = (r_bit_idx == c_LAST_BIT) ? r_hold[23] : r_shift[22];
        end
    end

    // Frame controller: pixel/bit counting, prefetch, latch gap and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_addr  <= '0;
            r_pix_idx   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_latch_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_busy     <= 1'b1;
                        r_pix_addr <= '0;
                    end
                end
                S_FETCH: begin
                    r_shift   <= w_fetch_word;
                    r_pix_idx <= '0;
                    r_bit_idx <= '0;
                    if (c_LAST_PIX != '0) begin
                        r_pix_addr <= c_ONE;
                    end
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_BIT) begin
                            if (r_pix_idx == c_LAST_PIX) begin
                                r_state     <= S_LATCH;
                                r_latch_cnt <= '0;
                            end else begin
                                r_shift   <= r_hold;
                                r_pix_idx <= w_next_idx;
                                r_bit_idx <= '0;
                                if (w_next_idx != c_LAST_PIX) begin
                                    r_pix_addr <= w_next_idx + c_ONE;
                                end
                            end
                        end else begin
                            r_shift   <= {r_shift[22:0], 1'b0};
                            r_bit_idx <= r_bit_idx + 5'd1;
                            // The address moved at the start of bit 0, so the
                            // store output has settled by the end of that bit.
                            if (r_bit_idx == 5'd0) begin
                                r_hold <= w_fetch_word;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (r_latch_cnt == c_RST_LAST) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_pix_addr <= '0;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    ws2812_bit_timer #(
        .T0H_CYC (c_T0H),
        .T1H_CYC (c_T1H),
        .BIT_CYC (c_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_go      (w_go),
        .i_bit     (w_bit),
        .o_ws      (ws_data),
        .o_bit_end (w_bit_end)
    );

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chain_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_chain_driver
//  Description : Directed bench for ws2812_chain_driver: three instances
//                (1 LED GRB @12 MHz, 3 LEDs RGB @12 MHz, 1 LED GRB @48 MHz).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_chain_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [0:0]  addr_a, addr_c;
    logic [1:0]  addr_b;
    logic [23:0] pd_a, pd_b, pd_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        ws_a, ws_b, ws_c;

    logic [23:0] mem_b [0:3];

    int   sel;
    logic w_ws, w_done, w_busy;
    int   w_addr;

    int   checks   = 0;
    int   failures = 0;

    logic ws_tr   [0:8191];
    logic done_tr [0:8191];
    logic busy_tr [0:8191];
    int   addr_tr [0:8191];

    always #5 clk = ~clk;

    ws2812_chain_driver #(.NUM_LEDS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pix_addr(addr_a),
        .pix_data(pd_a), .busy(busy_a), .done(done_a), .ws_data(ws_a));

    ws2812_chain_driver #(.NUM_LEDS(3), .COLOR_ORDER(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pix_addr(addr_b),
        .pix_data(pd_b), .busy(busy_b), .done(done_b), .ws_data(ws_b));

    ws2812_chain_driver #(.CLK_HZ(48000000), .NUM_LEDS(1), .RESET_US(10)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .pix_addr(addr_c),
        .pix_data(pd_c), .busy(busy_c), .done(done_c), .ws_data(ws_c));

    // Synchronous pixel stores, one cycle read latency
    always @(posedge clk) begin
        pd_a <= 24'hFF0000;
        pd_b <= mem_b[addr_b];
        pd_c <= 24'h00FF00;
    end

    always_comb begin
        w_ws   = ws_a;
        w_done = done_a;
        w_busy = busy_a;
        w_addr = int'(addr_a);
        case (sel)
            1: begin w_ws = ws_b; w_done = done_b; w_busy = busy_b; w_addr = int'(addr_b); end
            2: begin w_ws = ws_c; w_done = done_c; w_busy = busy_c; w_addr = int'(addr_c); end
            default: ;
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        start_a = (sel == 0) ? v : 1'b0;
        start_b = (sel == 1) ? v : 1'b0;
        start_c = (sel == 2) ? v : 1'b0;
    endtask

    // Sample k lands in the k-th cycle after the one in which start was high
    task automatic record(input int n, input int hold_until, input int pulse_at);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ws_tr[k]   = w_ws;
            done_tr[k] = w_done;
            busy_tr[k] = w_busy;
            addr_tr[k] = w_addr;
            drive_start((k < hold_until) || (k == pulse_at));
        end
    endtask

    // High time of a bit cell, or -1 if the high part is not one leading run
    function automatic int bit_hi(input int base, input int per);
        int lead = 0;
        int ones = 0;
        bit stop = 1'b0;
        for (int j = 0; j < per; j++) begin
            if (!ws_tr[base + j]) stop = 1'b1;
            if (!stop) lead++;
            if (ws_tr[base + j]) ones++;
        end
        return (ones == lead) ? lead : -1;
    endfunction

    function automatic int count_ws(input int lo, input int hi);
        int c = 0;
        for (int j = lo; j <= hi; j++) if (ws_tr[j]) c++;
        return c;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int c = 0;
        for (int j = lo; j <= hi; j++) if (done_tr[j]) c++;
        return c;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int c = 0;
        for (int j = lo; j <= hi; j++) if (busy_tr[j]) c++;
        return c;
    endfunction

    function automatic int first_done(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) if (done_tr[j]) return j;
        return -1;
    endfunction

    initial begin
        int          bad;
        int          h;
        logic [23:0] word;
        int          nz;

        mem_b[0] = 24'h000001;
        mem_b[1] = 24'h800000;
        mem_b[2] = 24'h00FF00;
        mem_b[3] = 24'h000000;
        sel      = 0;
        rst_n    = 1'b0;
        drive_start(1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ws",   int'(w_ws),   0);
        check("rst_busy", int'(w_busy), 0);
        check("rst_done", int'(w_done), 0);
        check("rst_addr", w_addr,       0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1 LED, GRB, FF0000 -> wire 00 FF 00
        @(negedge clk); drive_start(1'b1);
        record(1400, 1, 0);
        check("a_busy_fetch", int'(busy_tr[1]), 1);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("a_bit%0d_hi", i), bit_hi(2 + 15 * i, 15), (i >= 8 && i < 16) ? 8 : 4);
        end
        check("a_latch_low", count_ws(362, 1321), 0);
        check("a_done_at",   first_done(1, 1400), 1322);
        check("a_done_cnt",  count_done(1, 1400), 1);
        check("a_busy_last", int'(busy_tr[1321]), 1);
        check("a_busy_done", int'(busy_tr[1322]), 0);
        nz = 0;
        for (int k = 1; k <= 1400; k++) if (addr_tr[k] != 0) nz++;
        check("a_addr_zero", nz, 0);

        // start held high through done: back-to-back frames
        @(negedge clk); drive_start(1'b1);
        record(2700, 1330, 0);
        check("hold_done1",   first_done(1, 2700), 1322);
        check("hold_busy_nx", int'(busy_tr[1323]), 1);
        check("hold_ws_high", int'(ws_tr[1324]), 1);
        check("hold_done2",   first_done(1323, 2700), 2644);
        check("hold_done_n",  count_done(1, 2700), 2);

        // Reset mid-frame during a high phase
        @(negedge clk); drive_start(1'b1);
        record(152, 1, 0);
        check("mid_ws_pre", int'(ws_tr[152]), 1);
        rst_n = 1'b0;
        #1;
        check("mid_ws_rst",   int'(w_ws),   0);
        check("mid_busy_rst", int'(w_busy), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drive_start(1'b1);
        record(1400, 1, 0);
        check("post_done_at", first_done(1, 1400), 1322);
        check("post_bit8_hi", bit_hi(2 + 15 * 8, 15), 8);

        // 3 LEDs, RGB, with a start pulse while busy
        sel = 1;
        @(negedge clk); drive_start(1'b1);
        record(2100, 1, 500);
        bad = 0;
        for (int p = 0; p < 3; p++) begin
            word = 24'h0;
            for (int i = 0; i < 24; i++) begin
                h = bit_hi(2 + 15 * (24 * p + i), 15);
                if (h != 4 && h != 8) bad++;
                word = {word[22:0], (h == 8)};
            end
            check($sformatf("b_pix%0d", p), int'(word), int'(mem_b[p]));
        end
        check("b_bit_shape", bad, 0);
        nz = 0;
        for (int i = 0; i < 72; i++) if (!ws_tr[2 + 15 * i]) nz++;
        check("b_gapless",    nz, 0);
        check("b_addr_fetch", addr_tr[1],   0);
        check("b_addr_p0",    addr_tr[2],   1);
        check("b_addr_p1",    addr_tr[362], 2);
        check("b_addr_p2",    addr_tr[722], 2);
        check("b_addr_end",   addr_tr[2043], 0);
        check("b_latch_low",  count_ws(1082, 2041), 0);
        check("b_done_at",    first_done(1, 2100), 2042);
        check("b_done_cnt",   count_done(1, 2100), 1);
        check("b_idle_after", count_busy(2043, 2100), 0);

        // 48 MHz: T0H=17, T1H=34, BIT=60, latch 480
        sel = 2;
        @(negedge clk); drive_start(1'b1);
        record(1950, 1, 0);
        check("c_bit0_hi",  bit_hi(2, 60), 34);
        check("c_bit8_hi",  bit_hi(2 + 60 * 8, 60), 17);
        check("c_bit23_hi", bit_hi(2 + 60 * 23, 60), 17);
        nz = 0;
        for (int i = 0; i < 24; i++) if (!ws_tr[2 + 60 * i]) nz++;
        check("c_bit_period", nz, 0);
        check("c_done_at",  first_done(1, 1950), 1922);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
